// File: rtl/regfile_ctx_engine_if.sv
// Register-file port set plus save/load streams of the context engine.
// master: engine side (drives rf_rna/wn/d/we, out_*, in_ready); slave: CPU side.
interface regfile_ctx_engine_if;
    logic [4:0]  rf_rna;
    logic [31:0] rf_qa;
    logic [4:0]  rf_wn;
    logic [31:0] rf_d;
    logic        rf_we;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output rf_rna, rf_wn, rf_d, rf_we,
        input  rf_qa,
        output out_data, out_valid,
        input  out_ready,
        input  in_data, in_valid,
        output in_ready
    );

    modport slave (
        input  rf_rna, rf_wn, rf_d, rf_we,
        output rf_qa,
        input  out_data, out_valid,
        output out_ready,
        output in_data, in_valid,
        input  in_ready
    );
endinterface

// File: rtl/regfile_ctx_engine.sv
// Context save/restore engine: streams regs FIRST_REG..LAST_REG out (save)
// or writes a stream into them (load) while the CPU is stalled by busy.
// Ports: clk, clrn (async low), start_save/start_load/abort requests,
// busy/done status, cksum, and bus (regfile + streams, master modport).
// Optional: define REGFILE_CTX_CKSUM_EN to build the XOR stream checksum.
module regfile_ctx_engine #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start_save,
    input  logic        start_load,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] cksum,
    regfile_ctx_engine_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_RD,
        SAVE_TX,
        LOAD,
        DONE
    } state_t;

    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'(LAST_REG);

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;

    logic save_hs;
    logic load_hs;
    logic is_last;
    logic saving;

    // Abort kills any handshake in its cycle, so nothing is written or counted.
    assign save_hs = (state_q == SAVE_TX) & out_valid_q
                   & bus.out_ready & ~abort;
    assign load_hs = (state_q == LOAD) & in_ready_q
                   & bus.in_valid & ~abort;
    assign is_last = (idx_q == LAST);
    assign saving  = (state_q == SAVE_RD) | (state_q == SAVE_TX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        if (abort && state_q != IDLE) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_save) begin
                        state_d = SAVE_RD;
                        idx_d   = FIRST;
                    end else if (start_load) begin
                        state_d    = LOAD;
                        idx_d      = FIRST;
                        in_ready_d = 1'b1;
                    end
                end
                SAVE_RD: begin
                    out_data_d  = bus.rf_qa;
                    out_valid_d = 1'b1;
                    state_d     = SAVE_TX;
                end
                SAVE_TX: begin
                    if (save_hs) begin
                        out_valid_d = 1'b0;
                        if (is_last) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            state_d = SAVE_RD;
                        end
                    end
                end
                LOAD: begin
                    if (load_hs) begin
                        if (is_last) begin
                            state_d    = DONE;
                            in_ready_d = 1'b0;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            idx_q       <= FIRST;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign bus.rf_rna    = saving ? idx_q : 5'd0;
    assign bus.rf_we     = load_hs;
    assign bus.rf_wn     = load_hs ? idx_q : 5'd0;
    assign bus.rf_d      = load_hs ? bus.in_data : 32'd0;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;

`ifdef REGFILE_CTX_CKSUM_EN
    logic [31:0] cksum_q, cksum_d;

    always_comb begin
        cksum_d = cksum_q;
        if (state_q == IDLE && (start_save || start_load)) begin
            cksum_d = '0;
        end else if (save_hs) begin
            cksum_d = cksum_q ^ out_data_q;
        end else if (load_hs) begin
            cksum_d = cksum_q ^ bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign cksum = cksum_q;
`else
    assign cksum = '0;
`endif

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Bench for regfile_ctx_engine: regfile environment, stream model,
// per-cycle compare process and directed save/load/abort/reset scenarios.
module tb_regfile_ctx_engine;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        start_save = 1'b0;
    logic        start_load = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] cksum;

    regfile_ctx_engine_if bus ();

    regfile_ctx_engine #(.FIRST_REG(1), .LAST_REG(31)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .start_save (start_save),
        .start_load (start_load),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .cksum      (cksum),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Regfile environment: r0 reads zero, combinational read port.
    logic [31:0] rf [32];
    logic        pre_en = 1'b0;
    assign bus.rf_qa = rf[bus.rf_rna];

    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
        end else if (bus.rf_we && bus.rf_wn != 5'd0) begin
            rf[bus.rf_wn] <= bus.rf_d;
        end
    end

    // Load stream source: word k of the current load is ld_base + k.
    logic [31:0] ld_base = 32'd0;
    logic [31:0] ld_k = 32'd1;
    logic        ld_clr = 1'b0;
    assign bus.in_data = ld_base + ld_k;

    always @(posedge clk) begin
        if (ld_clr) ld_k <= 32'd1;
        else if (bus.in_valid && bus.in_ready && !abort) ld_k <= ld_k + 32'd1;
    end

    // out_ready source: constant 1, or repeating 1-0-0-1.
    logic rdy_mode = 1'b0;
    initial begin
        int ph;
        ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                bus.out_ready = (ph == 0 || ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                bus.out_ready = 1'b1;
                ph = 0;
            end
        end
    end

    // Behavioural model: what the regfile must hold, and the word
    // sequence a save must produce from it.
    logic [31:0] exp_rf [32];
    logic [31:0] sv_q [$];
    logic        sv_mode = 1'b0;
    logic        ld_mode = 1'b0;
    int          exp_wn = 1;
    int          hs_cnt = 0;
    int          we_cnt = 0;

    task automatic push_save();
        for (int i = 1; i <= 31; i++) sv_q.push_back(exp_rf[i]);
    endtask

    function automatic logic [31:0] xor_range(input logic [31:0] b);
        logic [31:0] x;
        x = '0;
        for (int i = 1; i <= 31; i++) x ^= b + 32'(i);
        return x;
    endfunction

    initial begin
        logic        hold_v;
        logic [31:0] hold_d;
        logic        exp_we;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (!clrn) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v && bus.out_valid)
                    chk("out_data_hold", bus.out_data, hold_d);
                hold_v = bus.out_valid & ~bus.out_ready;
                hold_d = bus.out_data;
                if (bus.out_valid && bus.out_ready) begin
                    hs_cnt++;
                    if (!sv_mode || sv_q.size() == 0)
                        chk("unexpected_word", 32'd1, 32'd0);
                    else
                        chk("save_word", bus.out_data, sv_q.pop_front());
                end
                exp_we = ld_mode & bus.in_valid & bus.in_ready & ~abort;
                chk("rf_we", {31'd0, bus.rf_we}, {31'd0, exp_we});
                if (bus.rf_we) begin
                    chk("rf_wn", {27'd0, bus.rf_wn}, 32'(exp_wn));
                    chk("rf_d", bus.rf_d, bus.in_data);
                    exp_wn++;
                    we_cnt++;
                end
                if (!sv_mode)
                    chk("rf_rna_idle", {27'd0, bus.rf_rna}, 32'd0);
                if (done)
                    chk("busy_in_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic pulse(input logic s, input logic l);
        @(posedge clk);
        #1;
        start_save = s;
        start_load = l;
        @(posedge clk);
        #1;
        start_save = 1'b0;
        start_load = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int n, output int fv);
        n = 0;
        fv = 0;
        while (!done && n < lim) begin
            @(posedge clk);
            #1;
            n++;
            if (fv == 0 && bus.out_valid) fv = n;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int n;
        int fv;
        bus.in_valid = 1'b0;

        // Reset values
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
        chk("rst_rf_rna", {27'd0, bus.rf_rna}, 32'd0);
        chk("rst_rf_wn", {27'd0, bus.rf_wn}, 32'd0);
        chk("rst_rf_d", bus.rf_d, 32'd0);
        chk("rst_cksum", cksum, 32'd0);
        pre_en = 1'b1;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
        for (int i = 0; i < 32; i++)
            exp_rf[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
        clrn = 1'b1;

        // Save, out_ready always high
        push_save();
        chk("model_first_word", sv_q[0], 32'h1000_0001);
        chk("model_last_word", sv_q[30], 32'h1000_001F);
        sv_mode = 1'b1;
        hs_cnt = 0;
        pulse(1'b1, 1'b0);
        wait_done(400, n, fv);
        chk("save_first_valid", 32'(fv), 32'd1);
        chk("save_done_cycle", 32'(n), 32'd62);
`ifdef REGFILE_CTX_CKSUM_EN
        chk("save_cksum", cksum, 32'h1000_0000);
        chk("save_cksum_model", cksum, xor_range(32'h1000_0000));
`else
        chk("save_cksum_off", cksum, 32'd0);
`endif
        @(posedge clk);
        #1;
        chk("save_busy_after", {31'd0, busy}, 32'd0);
        chk("save_hs_cnt", 32'(hs_cnt), 32'd31);
        chk("save_q_empty", 32'(sv_q.size()), 32'd0);
        sv_mode = 1'b0;

        // Load A5A5_0000+i every cycle
        ld_base = 32'hA5A5_0000;
        ld_clr = 1'b1;
        @(posedge clk);
        #1;
        ld_clr = 1'b0;
        exp_wn = 1;
        we_cnt = 0;
        ld_mode = 1'b1;
        bus.in_valid = 1'b1;
        pulse(1'b0, 1'b1);
        chk("load_in_ready", {31'd0, bus.in_ready}, 32'd1);
        wait_done(200, n, fv);
        chk("load_done_cycle", 32'(n), 32'd31);
        chk("load_we_cnt", 32'(we_cnt), 32'd31);
`ifdef REGFILE_CTX_CKSUM_EN
        chk("load_cksum", cksum, 32'hA5A5_0000);
`else
        chk("load_cksum_off", cksum, 32'd0);
`endif
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        ld_mode = 1'b0;
        chk("load_busy_after", {31'd0, busy}, 32'd0);
        chk("load_in_ready_after", {31'd0, bus.in_ready}, 32'd0);
        chk("load_r5", rf[5], 32'hA5A5_0005);
        chk("load_r0", rf[0], 32'd0);
        for (int i = 1; i <= 31; i++) exp_rf[i] = 32'hA5A5_0000 + 32'(i);
        for (int i = 0; i < 32; i++) chk("load_rf", rf[i], exp_rf[i]);

        // Save with 1-0-0-1 ready, start_load in same cycle and mid-save
        rdy_mode = 1'b1;
        bus.in_valid = 1'b1;
        push_save();
        sv_mode = 1'b1;
        hs_cnt = 0;
        pulse(1'b1, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        start_load = 1'b1;
        @(posedge clk);
        #1;
        start_load = 1'b0;
        wait_done(600, n, fv);
        @(posedge clk);
        #1;
        chk("tog_hs_cnt", 32'(hs_cnt), 32'd31);
        chk("tog_q_empty", 32'(sv_q.size()), 32'd0);
        chk("tog_busy_after", {31'd0, busy}, 32'd0);
        sv_mode = 1'b0;
        rdy_mode = 1'b0;
        bus.in_valid = 1'b0;

        // Abort a load after 10 words
        pre_en = 1'b1;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
        for (int i = 1; i <= 31; i++) exp_rf[i] = 32'h1000_0000 + 32'(i);
        ld_base = 32'hC3C3_0000;
        ld_clr = 1'b1;
        @(posedge clk);
        #1;
        ld_clr = 1'b0;
        exp_wn = 1;
        we_cnt = 0;
        ld_mode = 1'b1;
        bus.in_valid = 1'b1;
        pulse(1'b0, 1'b1);
        n = 0;
        while (ld_k != 32'd11 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_reach_10", ld_k, 32'd11);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_no_done2", {31'd0, done}, 32'd0);
        chk("abort_we_cnt", 32'(we_cnt), 32'd10);
        bus.in_valid = 1'b0;
        ld_mode = 1'b0;
        for (int i = 1; i <= 10; i++) exp_rf[i] = 32'hC3C3_0000 + 32'(i);
        chk("abort_r10", rf[10], 32'hC3C3_000A);
        chk("abort_r11", rf[11], 32'h1000_000B);
        for (int i = 0; i < 32; i++) chk("abort_rf", rf[i], exp_rf[i]);

        // Reset mid-save
        push_save();
        sv_mode = 1'b1;
        hs_cnt = 0;
        pulse(1'b1, 1'b0);
        n = 0;
        while (hs_cnt < 3 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_mid_progress", 32'(hs_cnt), 32'd3);
        @(posedge clk);
        #3;
        clrn = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_rf_rna", {27'd0, bus.rf_rna}, 32'd0);
        chk("rst_mid_out_data", bus.out_data, 32'd0);
        chk("rst_mid_cksum", cksum, 32'd0);
        sv_q.delete();
        sv_mode = 1'b0;
        @(posedge clk);
        #1;
        clrn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_stays_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/regfile_ctx_engine.md
Name: regfile_ctx_engine

Overview:
- Context save/restore engine that masters the register-file port set: drives read address rna, and write signals wn/d/we.
- Save operation:
  - Walks registers FIRST_REG..LAST_REG through the read port.
  - Streams each value out on a valid/ready interface.
- Load operation:
  - Accepts a valid/ready stream.
  - Writes each word into consecutive registers through the write port.
- Sits beside the single-cycle CPU. The CPU is stalled (busy) while the engine owns the register file.

Parameters:
- FIRST_REG, 1, first register index transferred; must be ≥1.
- LAST_REG, 31, last register index transferred; must be ≥FIRST_REG and ≤31.

Ports:
- clk  input  1  clock, rising edge.
- clrn  input  1  reset, asynchronous, active-low.
- start_save  input  1  one-cycle request to begin a save.
- start_load  input  1  one-cycle request to begin a load.
- abort  input  1  synchronous abort of the current operation.
- busy  output  1  high while not IDLE; CPU stall.
- done  output  1  one-cycle pulse when an operation completes normally.
- rf_rna  output  5  register-file read address.
- rf_qa  input  32  register-file read data; combinational from rf_rna.
- rf_wn  output  5  register-file write address.
- rf_d  output  32  register-file write data.
- rf_we  output  1  register-file write enable.
- out_data  output  32  save stream data.
- out_valid  output  1  save stream valid.
- out_ready  input  1  save stream ready.
- in_data  input  32  load stream data.
- in_valid  input  1  load stream valid.
- in_ready  output  1  load stream ready.
- cksum  output  32  XOR checksum; see Optional Feature.

Behaviour:
- Reset (clrn=0, async):
  - State IDLE, idx=FIRST_REG.
  - busy=0, done=0, out_valid=0, out_data=0, in_ready=0, rf_we=0, rf_rna=0, rf_wn=0, rf_d=0, cksum=0.
- States: IDLE, SAVE_RD, SAVE_TX, LOAD, DONE.
- IDLE:
  - start_save → SAVE_RD, idx=FIRST_REG.
  - else start_load → LOAD, idx=FIRST_REG.
  - Both asserted in the same cycle: save wins; start_load is dropped.
  - start_* outside IDLE is ignored.
- SAVE_RD (one cycle):
  - rf_rna=idx; out_data<=rf_qa at the clock edge; out_valid<=1; → SAVE_TX.
- SAVE_TX:
  - rf_rna=idx; out_valid held high; out_data held stable until handshake.
  - Handshake = out_valid & out_ready. On handshake: out_valid<=0.
  - If idx==LAST_REG → DONE; else idx<=idx+1, → SAVE_RD.
  - Throughput: 2 cycles per register minimum. Latency start_save → first out_valid: 2 edges.
- LOAD:
  - in_ready=1 (registered, asserted the cycle after leaving IDLE).
  - On in_valid & in_ready, combinationally in the same cycle: rf_we=1, rf_wn=idx, rf_d=in_data. The register is written at that edge.
  - If idx==LAST_REG → DONE, in_ready<=0; else idx<=idx+1.
  - No in_valid: rf_we=0, nothing advances.
  - Throughput: 1 register per cycle.
- DONE:
  - done=1 for exactly one cycle; busy=1 in DONE; → IDLE.
- rf_we:
  - Never asserted outside LOAD.
  - rf_wn is never 0, since FIRST_REG ≥1.
- rf_rna=0 when not in SAVE_RD/SAVE_TX.
- abort (any non-IDLE state):
  - Next state IDLE; out_valid<=0; in_ready<=0; no done pulse.
  - A load handshake in the abort cycle is suppressed: rf_we=0.
  - Registers already written stay written.
- busy = (state != IDLE).
- A reset mid-operation returns all outputs to their reset values immediately; a partial transfer is not resumed.

Optional Feature:
- Macro: REGFILE_CTX_CKSUM_EN.
- Defined:
  - cksum is cleared to 0 when an operation starts (IDLE → SAVE_RD/LOAD).
  - On every stream handshake, cksum <= cksum ^ word. The word is out_data for save, in_data for load.
  - Value is held after DONE until the next start.
- Undefined: cksum is tied to 0 and no checksum logic is built.

Test Plan:
- Save with regfile preloaded r_i=32'h1000_0000+i, out_ready=1 always → 31 words 0x10000001..0x1000001F in order; done pulses 62 cycles after start_save edge; busy=0 the next cycle.
- Load of in_data=32'hA5A5_0000+i with in_valid=1 every cycle → rf_we high 31 consecutive cycles, rf_wn 1..31; regfile then reads r5=0xA5A50005; r0 still 0.
- Save with out_ready toggling 1-0-0-1 → out_data stable while out_valid & !out_ready; no word lost or duplicated; 31 handshakes total.
- start_save and start_load in the same cycle → save runs; rf_we never asserted; start_load pulse during save is ignored.
- abort during load after 10 words → in_ready low next cycle, no done; r1..r10 updated, r11 unchanged. Separately, clrn low mid-save → out_valid=0 and busy=0 asynchronously.
- With REGFILE_CTX_CKSUM_EN: load words 1,2,4 using FIRST_REG=1, LAST_REG=3 → cksum=7 after done. Without the macro → cksum=0 throughout.
